serial_subtractor: RTL and testbench
====================================

Name: serial_subtractor

Overview:
Bit-serial, multi-cycle subtractor that computes A − B one bit per clock, LSB first. It is the inverse-operation companion of the team's registered 4-bit adder and uses the same operand and flag style: A, B, En, Overflow. Results are held in registers until the next operation completes. It is intended for area-constrained datapath slices and as a self-check source for adder benches.

Parameters:
WIDTH, 4, operand and result width in bits (≥2).

Ports:
Clk  input  1  rising-edge clock
Reset  input  1  asynchronous, active-high reset
En  input  1  start request, sampled on rising Clk
A  input  WIDTH  minuend, captured when start is accepted
B  input  WIDTH  subtrahend, captured when start is accepted
Diff  output  WIDTH  registered result A − B (mod 2^WIDTH)
Borrow  output  1  registered unsigned borrow (1 when A < B unsigned)
Overflow  output  1  registered two's-complement overflow
Busy  output  1  high while bits are being processed
Done  output  1  one-cycle pulse when Diff, Borrow and Overflow update

Behaviour:
- Reset (asynchronous, any time, including mid-operation):
  - state IDLE.
  - Diff=0, Borrow=0, Overflow=0, Busy=0, Done=0.
  - Internal shift registers, borrow bit and counter cleared.
  - The in-flight operation is discarded.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - En=1 at an edge: latch A→ra and B→rb, clear br (internal borrow) and cnt, go to SHIFT, Busy=1.
  - En=0: stay in IDLE.
- SHIFT, each edge processes bit 0 of ra/rb:
  - d = ra[0] ^ rb[0] ^ br
  - br_next = (~ra[0] & rb[0]) | (~(ra[0] ^ rb[0]) & br)
  - Shift ra and rb right by 1.
  - Shift d into the MSB of an internal result register.
  - Latch the operand MSBs before shifting them out; they are needed for Overflow.
  - cnt increments each edge.
  - At the edge processing bit WIDTH−1, go to DONE and, on that same edge:
    - Diff = full result
    - Borrow = final br
    - Overflow = (A[MSB] != B[MSB]) && (Diff[MSB] != A[MSB])
    - Done=1, Busy=0
- Latency: En sampled at edge k → Done high in the cycle after edge k+WIDTH (4 cycles for WIDTH=4).
- DONE lasts exactly 1 cycle and behaves as IDLE for En:
  - En=1: accept new operands, go to SHIFT (back-to-back, no gap cycle).
  - En=0: go to IDLE.
  - Done returns to 0 on the next edge in either case.
- En while Busy=1 is ignored. A/B changes while busy do not affect the result.
- Diff, Borrow and Overflow change only at completion; they hold indefinitely otherwise.
- Width rules:
  - All arithmetic is modulo 2^WIDTH.
  - Borrow is the unsigned compare.
  - Overflow is the signed compare.
  - Both flags are valid simultaneously.

Test Plan:
- WIDTH=4, A=5, B=3, En pulse 1 cycle → Busy high 4 cycles; then Done=1 for 1 cycle with Diff=4'h2, Borrow=0, Overflow=0.
- A=3, B=5 → Diff=4'hE, Borrow=1, Overflow=0; Done exactly 4 cycles after the start edge.
- A=4'h7, B=4'hF (7 − (−1)) → Diff=4'h8, Borrow=1, Overflow=1. Then A=4'h8, B=4'h1 → Diff=4'h7, Borrow=0, Overflow=1.
- En held high continuously with A=9, B=9, then A=0, B=1 → two consecutive results with no idle gap: Diff=0/Borrow=0, then Diff=4'hF/Borrow=1, Overflow=0. Operand changes during Busy are ignored.
- Start A=6, B=2, assert Reset at cycle 2 of SHIFT → all outputs 0 immediately (asynchronous), no Done pulse. A fresh start after reset release yields Diff=4'h4.
- Exhaustive sweep of all 256 A/B pairs, Clk period 10 ns → each Diff/Borrow/Overflow matches a golden model computed with 5-bit subtraction and sign check.

Source files
------------

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes A - B one bit per clock, LSB first, and
// publishes Diff with unsigned Borrow and signed Overflow flags on completion.
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             En,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Diff,
  output logic             Borrow,
  output logic             Overflow,
  output logic             Busy,
  output logic             Done
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic             r_br;
  logic [CNT_W-1:0] r_cnt;
  logic             r_a_msb;
  logic             r_b_msb;

  logic             w_start;
  logic             w_last;
  logic             w_d;
  logic             w_br_next;
  logic [WIDTH-1:0] w_res_next;
  logic             w_ovf;

  // DONE accepts a new start just like IDLE, which gives back-to-back operation.
  assign w_start    = En && (r_state != SHIFT);
  assign w_last     = (r_state == SHIFT) && (r_cnt == LAST_BIT);

  assign w_d        = r_a[0] ^ r_b[0] ^ r_br;
  assign w_br_next  = (~r_a[0] & r_b[0]) | (~(r_a[0] ^ r_b[0]) & r_br);
  assign w_res_next = {w_d, r_res[WIDTH-1:1]};
  assign w_ovf      = (r_a_msb != r_b_msb) && (w_d != r_a_msb);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (En) w_next = SHIFT;
      SHIFT:   if (w_last) w_next = DONE;
      DONE:    w_next = En ? SHIFT : IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_a      <= '0;
      r_b      <= '0;
      r_res    <= '0;
      r_br     <= 1'b0;
      r_cnt    <= '0;
      r_a_msb  <= 1'b0;
      r_b_msb  <= 1'b0;
      Diff     <= '0;
      Borrow   <= 1'b0;
      Overflow <= 1'b0;
      Busy     <= 1'b0;
      Done     <= 1'b0;
    end else begin
      Done <= w_last;
      if (w_start) begin
        r_a     <= A;
        r_b     <= B;
        r_res   <= '0;
        r_br    <= 1'b0;
        r_cnt   <= '0;
        r_a_msb <= A[WIDTH-1];
        r_b_msb <= B[WIDTH-1];
        Busy    <= 1'b1;
      end else if (r_state == SHIFT) begin
        r_a   <= r_a >> 1;
        r_b   <= r_b >> 1;
        r_br  <= w_br_next;
        r_cnt <= r_cnt + CNT_W'(1);
        r_res <= w_res_next;
        // Results are published only on the edge that retires the MSB.
        if (w_last) begin
          Diff     <= w_res_next;
          Borrow   <= w_br_next;
          Overflow <= w_ovf;
          Busy     <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor (WIDTH=4): latency, flags, back-to-back,
// asynchronous reset and an exhaustive operand sweep.
module tb_serial_subtractor;

  logic       Clk;
  logic       Reset;
  logic       En;
  logic [3:0] A;
  logic [3:0] B;
  logic [3:0] Diff;
  logic       Borrow;
  logic       Overflow;
  logic       Busy;
  logic       Done;

  int n_tests;
  int n_fail;

  serial_subtractor #(.WIDTH(4)) dut (
    .Clk(Clk), .Reset(Reset), .En(En), .A(A), .B(B),
    .Diff(Diff), .Borrow(Borrow), .Overflow(Overflow),
    .Busy(Busy), .Done(Done)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Starts one operation and waits (bounded) for Done; operands are scrambled
  // right after the start edge to show they are not re-sampled while busy.
  task automatic run_op(input logic [3:0] a, input logic [3:0] b,
                        output logic [3:0] d, output logic bo, output logic ov,
                        output int lat, output logic busy_at_done, output logic ok);
    @(negedge Clk);
    En = 1'b1; A = a; B = b;
    @(negedge Clk);
    En = 1'b0; A = ~a; B = ~b;
    lat = 0; ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (Done) begin
        ok = 1'b1;
        break;
      end
      if (Busy) lat++;
      @(negedge Clk);
    end
    d = Diff; bo = Borrow; ov = Overflow; busy_at_done = Busy;
  endtask

  task automatic test_reset();
    Reset = 1'b1; En = 1'b0; A = 4'h0; B = 4'h0;
    repeat (3) @(negedge Clk);
    n_tests++;
    if ({Diff, Borrow, Overflow, Busy, Done} !== 8'h00) begin
      $display("FAIL reset_outputs: got %b, expected 00000000", {Diff, Borrow, Overflow, Busy, Done});
      n_fail++;
    end
    Reset = 1'b0;
    repeat (3) @(negedge Clk);
    n_tests++;
    if (Busy !== 1'b0 || Done !== 1'b0) begin
      $display("FAIL idle_no_start: Busy=%b Done=%b, expected 0 0", Busy, Done);
      n_fail++;
    end
  endtask

  task automatic test_basic();
    logic [3:0] d; logic bo, ov, bz, ok; int lat;
    run_op(4'h5, 4'h3, d, bo, ov, lat, bz, ok);
    n_tests++;
    if (!ok || lat != 4 || bz !== 1'b0) begin
      $display("FAIL basic_timing: done=%b busy_cycles=%0d busy=%b, expected 1 4 0", ok, lat, bz);
      n_fail++;
    end
    n_tests++;
    if ({d, bo, ov} !== {4'h2, 1'b0, 1'b0}) begin
      $display("FAIL basic_5m3: Diff=%h B=%b O=%b, expected 2 0 0", d, bo, ov);
      n_fail++;
    end
    @(negedge Clk);
    n_tests++;
    if (Done !== 1'b0) begin
      $display("FAIL done_pulse_width: Done=%b one cycle later, expected 0", Done);
      n_fail++;
    end
    run_op(4'h3, 4'h5, d, bo, ov, lat, bz, ok);
    n_tests++;
    if (!ok || lat != 4 || {d, bo, ov} !== {4'hE, 1'b1, 1'b0}) begin
      $display("FAIL basic_3m5: done=%b lat=%0d Diff=%h B=%b O=%b, expected 1 4 e 1 0", ok, lat, d, bo, ov);
      n_fail++;
    end
  endtask

  task automatic test_overflow();
    logic [3:0] d; logic bo, ov, bz, ok; int lat;
    run_op(4'h7, 4'hF, d, bo, ov, lat, bz, ok);
    n_tests++;
    if (!ok || {d, bo, ov} !== {4'h8, 1'b1, 1'b1}) begin
      $display("FAIL ovf_7mF: done=%b Diff=%h B=%b O=%b, expected 1 8 1 1", ok, d, bo, ov);
      n_fail++;
    end
    run_op(4'h8, 4'h1, d, bo, ov, lat, bz, ok);
    n_tests++;
    if (!ok || {d, bo, ov} !== {4'h7, 1'b0, 1'b1}) begin
      $display("FAIL ovf_8m1: done=%b Diff=%h B=%b O=%b, expected 1 7 0 1", ok, d, bo, ov);
      n_fail++;
    end
    repeat (6) @(negedge Clk);
    n_tests++;
    if ({Diff, Borrow, Overflow, Done} !== {4'h7, 1'b0, 1'b1, 1'b0}) begin
      $display("FAIL result_hold: Diff=%h B=%b O=%b Done=%b, expected 7 0 1 0", Diff, Borrow, Overflow, Done);
      n_fail++;
    end
  endtask

  task automatic test_back_to_back();
    @(negedge Clk);
    En = 1'b1; A = 4'h9; B = 4'h9;
    @(negedge Clk);
    @(negedge Clk);
    A = 4'h0; B = 4'h1;
    repeat (3) @(negedge Clk);
    n_tests++;
    if ({Done, Busy, Diff, Borrow, Overflow} !== {1'b1, 1'b0, 4'h0, 1'b0, 1'b0}) begin
      $display("FAIL b2b_first: Done=%b Busy=%b Diff=%h B=%b O=%b, expected 1 0 0 0 0", Done, Busy, Diff, Borrow, Overflow);
      n_fail++;
    end
    @(negedge Clk);
    En = 1'b0;
    n_tests++;
    if (Busy !== 1'b1 || Done !== 1'b0) begin
      $display("FAIL b2b_no_gap: Busy=%b Done=%b, expected 1 0", Busy, Done);
      n_fail++;
    end
    repeat (4) @(negedge Clk);
    n_tests++;
    if ({Done, Diff, Borrow, Overflow} !== {1'b1, 4'hF, 1'b1, 1'b0}) begin
      $display("FAIL b2b_second: Done=%b Diff=%h B=%b O=%b, expected 1 f 1 0", Done, Diff, Borrow, Overflow);
      n_fail++;
    end
  endtask

  task automatic test_async_reset();
    logic [3:0] d; logic bo, ov, bz, ok; int lat;
    logic saw_done;
    @(negedge Clk);
    En = 1'b1; A = 4'h6; B = 4'h2;
    @(negedge Clk);
    En = 1'b0;
    @(negedge Clk);
    #2 Reset = 1'b1;
    #1;
    n_tests++;
    if ({Diff, Borrow, Overflow, Busy, Done} !== 8'h00) begin
      $display("FAIL async_reset: got %b, expected 00000000", {Diff, Borrow, Overflow, Busy, Done});
      n_fail++;
    end
    @(negedge Clk);
    Reset = 1'b0;
    saw_done = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge Clk);
      if (Done || Busy) saw_done = 1'b1;
    end
    n_tests++;
    if (saw_done !== 1'b0) begin
      $display("FAIL reset_discard: activity=%b after reset, expected 0", saw_done);
      n_fail++;
    end
    run_op(4'h6, 4'h2, d, bo, ov, lat, bz, ok);
    n_tests++;
    if (!ok || {d, bo, ov} !== {4'h4, 1'b0, 1'b0}) begin
      $display("FAIL post_reset_6m2: done=%b Diff=%h B=%b O=%b, expected 1 4 0 0", ok, d, bo, ov);
      n_fail++;
    end
  endtask

  task automatic test_sweep();
    logic [3:0] d; logic bo, ov, bz, ok; int lat;
    logic [4:0] g;
    logic [3:0] ga, gb;
    int errs;
    errs = 0;
    for (int ia = 0; ia < 16; ia++) begin
      for (int ib = 0; ib < 16; ib++) begin
        ga = ia[3:0]; gb = ib[3:0];
        g = {1'b0, ga} - {1'b0, gb};
        run_op(ga, gb, d, bo, ov, lat, bz, ok);
        if (!ok || lat != 4 || d !== g[3:0] || bo !== g[4] ||
            ov !== ((ga[3] != gb[3]) && (g[3] != ga[3]))) begin
          if (errs < 8)
            $display("FAIL sweep_%h_%h: done=%b lat=%0d Diff=%h B=%b O=%b, expected Diff=%h B=%b O=%b",
                     ga, gb, ok, lat, d, bo, ov, g[3:0], g[4], (ga[3] != gb[3]) && (g[3] != ga[3]));
          errs++;
        end
      end
    end
    n_tests++;
    if (errs != 0) begin
      $display("FAIL sweep_total: %0d pairs wrong, expected 0", errs);
      n_fail++;
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_basic();
    test_overflow();
    test_back_to_back();
    test_async_reset();
    test_sweep();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
